// File: rtl/spi_reg_target_pkg.sv
// Shared state encoding and command-byte layout for the SPI register target.
package spi_reg_target_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WDATA = 2'd2,
    ST_RDATA = 2'd3
  } state_t;

  localparam int CMD_RW_BIT = 7;
  localparam int DEF_ADDR_W = 7;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with one-cycle rise/fall pulses; latency STAGES clk to level.
// No backpressure; edge pulses are suppressed until the chain holds real samples after reset.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic [STAGES:0]   fill_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
      fill_q <= {fill_q[STAGES-1:0], 1'b1};
    end
  end

  // A pin already low when reset releases must not look like a fresh edge.
  assign level = sync_q[STAGES-1];
  assign rise  = fill_q[STAGES] & level & ~prev_q;
  assign fall  = fill_q[STAGES] & ~level & prev_q;

endmodule

// File: rtl/spi_reg_target.sv
// SPI mode-0 target decoding command/data bytes into single-cycle register strobes.
// Strobes follow the completing sck edge by SYNC_STAGES+1 clk; no backpressure, host paces.
module spi_reg_target
  import spi_reg_target_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy,
  output logic              frame_err
);

  logic sck_lvl_unused, sck_rise, sck_fall;
  logic cs_s, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_q;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk   (clk),
    .reset (reset),
    .din   (sck),
    .level (sck_lvl_unused),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk   (clk),
    .reset (reset),
    .din   (cs_n),
    .level (cs_s),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mosi_q <= '0;
    else        mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
  end

  state_t      state;
  logic [2:0]  bit_cnt;
  logic [7:0]  rx_sh, tx_sh;
  logic        miso_q, we_inc, rd_inc, rd_load;
  logic        active, bit_rise, byte_done, partial;
  logic [7:0]  rx_byte;

  always_comb begin
    active    = (state != ST_IDLE);
    bit_rise  = active & sck_rise;
    byte_done = bit_rise & (bit_cnt == 3'd7);
    rx_byte   = {rx_sh[6:0], mosi_q[SYNC_STAGES-1]};
    partial   = bit_rise ? (bit_cnt != 3'd7) : (bit_cnt != 3'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      rx_sh     <= '0;
      tx_sh     <= '0;
      miso_q    <= 1'b0;
      we_inc    <= 1'b0;
      rd_inc    <= 1'b0;
      rd_load   <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      frame_err <= 1'b0;
      we_inc    <= 1'b0;
      rd_inc    <= 1'b0;
      rd_load   <= reg_re;

      if (we_inc) reg_addr <= reg_addr + ADDR_W'(1);
      if (rd_inc) reg_re <= 1'b1;

      // Read data lands one cycle after reg_re, ahead of the next sck fall.
      if (rd_load) begin
        tx_sh <= reg_rdata;
      end else if (active && sck_fall) begin
        miso_q <= tx_sh[7];
        tx_sh  <= {tx_sh[6:0], 1'b0};
      end

      if (bit_rise) begin
        rx_sh   <= rx_byte;
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (byte_done) begin
        case (state)
          ST_CMD: begin
            reg_addr <= ADDR_W'(rx_byte[6:0]);
            if (rx_byte[CMD_RW_BIT]) begin
              reg_re <= 1'b1;
              state  <= ST_RDATA;
            end else begin
              state  <= ST_WDATA;
            end
          end
          ST_WDATA: begin
            reg_we    <= 1'b1;
            reg_wdata <= rx_byte;
            we_inc    <= 1'b1;
          end
          ST_RDATA: begin
            reg_addr <= reg_addr + ADDR_W'(1);
            rd_inc   <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end

      // Framing overrides the byte-level state change but never the strobes above.
      if (cs_fall) begin
        state   <= ST_CMD;
        bit_cnt <= '0;
        rx_sh   <= '0;
        tx_sh   <= '0;
        miso_q  <= 1'b0;
      end else if (cs_rise) begin
        state   <= ST_IDLE;
        bit_cnt <= '0;
        miso_q  <= 1'b0;
        if (active && partial) frame_err <= 1'b1;
      end
    end
  end

  assign busy    = (state != ST_IDLE);
  assign miso_oe = ~cs_s;
  assign miso    = miso_oe & miso_q;

endmodule

// File: tb/tb_spi_reg_target.sv
// Directed bench for spi_reg_target: host drives SCK at clk/8, strobes are logged and checked.
module tb_spi_reg_target;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sck = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, miso_oe, reg_we, reg_re, busy, frame_err;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata, reg_rdata;

  assign reg_rdata = {reg_addr, 1'b1};

  spi_reg_target #(.ADDR_W(7), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .sck       (sck),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail = 0;
  int         we_n = 0, re_n = 0, fe_n = 0, both_n = 0;
  logic [6:0] we_addr [64];
  logic [7:0] we_data [64];
  logic [6:0] re_addr [64];

  always @(negedge clk) begin
    if (reg_we && we_n < 64) begin
      we_addr[we_n] = reg_addr;
      we_data[we_n] = reg_wdata;
    end
    if (reg_we) we_n = we_n + 1;
    if (reg_re && re_n < 64) re_addr[re_n] = reg_addr;
    if (reg_re) re_n = re_n + 1;
    if (frame_err) fe_n = fe_n + 1;
    if (reg_we && reg_re) both_n = both_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      mosi = tx[7-i];
      repeat (4) @(negedge clk);
      rx[7-i] = miso;
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  logic [7:0] rx;
  int         bw, br, bf;

  initial begin
    #2 reset = 1'b0;
    #1;
    check("reset_ctrl_outs", {miso, miso_oe, reg_we, reg_re, busy, frame_err}, 32'h0);
    check("reset_addr_data", {reg_addr, reg_wdata}, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    check("idle_busy", busy, 1'b0);

    // Write burst
    bw = we_n; br = re_n;
    cs_low();
    check("wr_busy_start", busy, 1'b1);
    check("wr_miso_oe", miso_oe, 1'b1);
    spi_bits(8'h05, 8, rx);
    spi_bits(8'hA5, 8, rx);
    spi_bits(8'h3C, 8, rx);
    check("wr_busy_end", busy, 1'b1);
    cs_high();
    check("wr_busy_idle", busy, 1'b0);
    check("wr_count", we_n - bw, 2);
    check("wr0", {we_addr[bw], we_data[bw]}, {7'h05, 8'hA5});
    check("wr1", {we_addr[bw+1], we_data[bw+1]}, {7'h06, 8'h3C});
    check("wr_no_re", re_n - br, 0);
    check("wr_addr_after", reg_addr, 7'h07);

    // Read burst with prefetch
    bw = we_n; br = re_n;
    cs_low();
    spi_bits(8'h90, 8, rx);
    check("rd_cmd_miso", rx, 8'h00);
    spi_bits(8'h00, 8, rx);
    check("rd_byte0", rx, 8'h21);
    spi_bits(8'h00, 8, rx);
    check("rd_byte1", rx, 8'h23);
    cs_high();
    check("rd_count", re_n - br, 3);
    check("rd_addr0", re_addr[br], 7'h10);
    check("rd_addr1", re_addr[br+1], 7'h11);
    check("rd_addr2", re_addr[br+2], 7'h12);
    check("rd_no_we", we_n - bw, 0);

    // Address wrap
    bw = we_n;
    cs_low();
    spi_bits(8'h7F, 8, rx);
    spi_bits(8'h11, 8, rx);
    spi_bits(8'h22, 8, rx);
    cs_high();
    check("wrap_count", we_n - bw, 2);
    check("wrap0", {we_addr[bw], we_data[bw]}, {7'h7F, 8'h11});
    check("wrap1", {we_addr[bw+1], we_data[bw+1]}, {7'h00, 8'h22});

    // Aborted frame after 5 data bits
    bw = we_n; bf = fe_n;
    cs_low();
    spi_bits(8'h20, 8, rx);
    spi_bits(8'hF0, 5, rx);
    cs_high();
    check("abort_frame_err", fe_n - bf, 1);
    check("abort_no_we", we_n - bw, 0);
    check("abort_idle", busy, 1'b0);
    check("abort_addr", reg_addr, 7'h20);
    bw = we_n; bf = fe_n;
    cs_low();
    spi_bits(8'h01, 8, rx);
    spi_bits(8'h55, 8, rx);
    cs_high();
    check("post_abort_count", we_n - bw, 1);
    check("post_abort_wr", {we_addr[bw], we_data[bw]}, {7'h01, 8'h55});
    check("post_abort_no_fe", fe_n - bf, 0);

    // Reset in the middle of a read data byte
    cs_low();
    spi_bits(8'h90, 8, rx);
    spi_bits(8'h00, 3, rx);
    reset = 1'b0;
    #1;
    check("mid_reset_ctrl", {miso, miso_oe, reg_we, reg_re, busy, frame_err}, 32'h0);
    check("mid_reset_addr_data", {reg_addr, reg_wdata}, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    bw = we_n; br = re_n;
    spi_bits(8'h05, 8, rx);
    spi_bits(8'hAA, 8, rx);
    check("post_reset_busy", busy, 1'b0);
    check("post_reset_no_we", we_n - bw, 0);
    check("post_reset_no_re", re_n - br, 0);
    cs_high();

    // Back-to-back frames with a 3-clk gap
    bw = we_n;
    cs_low();
    spi_bits(8'h30, 8, rx);
    spi_bits(8'h77, 8, rx);
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    @(negedge clk);
    check("b2b_oe_lag_hi", miso_oe, 1'b1);
    @(negedge clk);
    check("b2b_oe_off", miso_oe, 1'b0);
    @(negedge clk);
    cs_n = 1'b0;
    @(negedge clk);
    check("b2b_oe_lag_lo", miso_oe, 1'b0);
    @(negedge clk);
    check("b2b_oe_on", miso_oe, 1'b1);
    repeat (2) @(negedge clk);
    spi_bits(8'h40, 8, rx);
    spi_bits(8'h88, 8, rx);
    spi_bits(8'h99, 8, rx);
    cs_high();
    check("b2b_count", we_n - bw, 3);
    check("b2b_f1", {we_addr[bw], we_data[bw]}, {7'h30, 8'h77});
    check("b2b_f2a", {we_addr[bw+1], we_data[bw+1]}, {7'h40, 8'h88});
    check("b2b_f2b", {we_addr[bw+2], we_data[bw+2]}, {7'h41, 8'h99});
    check("we_re_exclusive", both_n, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
